// File: rtl/fading_move_board_pkg.sv
// Shared cell and response encodings for the fading tic-tac-toe board recorder.
package fading_board_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_O     = 2'b01,
        CELL_X     = 2'b10
    } cell_e;

    typedef enum logic [1:0] {
        RESP_OK   = 2'b00,
        RESP_TURN = 2'b01,
        RESP_OCC  = 2'b10,
        RESP_BAD  = 2'b11
    } resp_e;

endpackage

// File: rtl/fading_move_board_if.sv
// Move request / response handshake between move-input logic and the board recorder.
interface fading_move_board_if #(
    parameter int PW = 4
);
    logic          move_valid;
    logic          move_x;
    logic [PW-1:0] move_pos;
    logic          resp_valid;
    logic [1:0]    resp_code;

    modport master (
        output move_valid, move_x, move_pos,
        input  resp_valid, resp_code
    );

    modport slave (
        input  move_valid, move_x, move_pos,
        output resp_valid, resp_code
    );
endinterface

// File: rtl/fading_move_board_queue.sv
// Circular FIFO of piece positions for one player; push and pop may coincide at full.
module piece_queue #(
    parameter int DEPTH = 3,
    parameter int PW    = 4,
    localparam int CNTW = $clog2(DEPTH + 1),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [PW-1:0]   din,
    output logic [PW-1:0]   head,
    output logic [CNTW-1:0] count
);
    logic [PW-1:0]   mem_q [DEPTH];
    logic [IW-1:0]   head_idx_q, tail_idx_q;
    logic [CNTW-1:0] cnt_q;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_idx_q <= '0;
            tail_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (push) tail_idx_q <= wrap_inc(tail_idx_q);
            if (pop)  head_idx_q <= wrap_inc(head_idx_q);
            cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Storage needs no reset: entries are only read once the count says they are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_idx_q] <= din;
    end

    assign head  = mem_q[head_idx_q];
    assign count = cnt_q;
endmodule

// File: rtl/fading_move_board.sv
// Board-state recorder: validates moves, keeps per-player piece history, evicts the oldest piece.
module fading_move_board
    import fading_board_pkg::*;
#(
    parameter int CELLS   = 9,
    parameter int DEPTH   = 3,
    parameter int FADE_EN = 1,
    parameter int FIRST_X = 1,
    parameter int PW      = $clog2(CELLS),
    parameter int CW      = $clog2(CELLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 freeze,
    fading_move_board_if.slave   mv,
    output logic [2*CELLS-1:0]   board,
    output logic                 turn_x,
    output logic [CW-1:0]        x_count,
    output logic [CW-1:0]        o_count,
    output logic                 fade_valid,
    output logic [PW-1:0]        fade_pos
);
    localparam int QD  = (FADE_EN != 0) ? DEPTH : CELLS;
    localparam int QCW = $clog2(QD + 1);

    logic [2*CELLS-1:0] board_q, board_d;
    logic               turn_q;
    logic               resp_valid_q;
    logic [1:0]         resp_code_q, resp_code_d;
    logic [QCW-1:0]     xq_cnt, oq_cnt, mover_cnt;
    logic [PW-1:0]      xq_head, oq_head, mover_head;
    logic               pos_ok, accept, evict;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input logic [PW-1:0] p);
        return b[2*int'(p) +: 2];
    endfunction

    assign pos_ok     = int'(mv.move_pos) < CELLS;
    assign mover_cnt  = turn_q ? xq_cnt : oq_cnt;
    assign mover_head = turn_q ? xq_head : oq_head;

    always_comb begin
        resp_code_d = resp_code_q;
        accept      = 1'b0;
        evict       = 1'b0;
        board_d     = board_q;
        if (mv.move_valid) begin
            if (freeze || !pos_ok)                                resp_code_d = RESP_BAD;
            else if (mv.move_x != turn_q)                         resp_code_d = RESP_TURN;
            else if (cell_at(board_q, mv.move_pos) != CELL_EMPTY) resp_code_d = RESP_OCC;
            else begin
                resp_code_d = RESP_OK;
                accept      = 1'b1;
            end
        end
        // Oldest piece leaves in the same update that places the new one.
        evict = accept && (FADE_EN != 0) && (mover_cnt == QCW'(DEPTH));
        if (evict)  board_d[2*int'(mover_head) +: 2] = CELL_EMPTY;
        if (accept) board_d[2*int'(mv.move_pos) +: 2] = turn_q ? CELL_X : CELL_O;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            board_q      <= '0;
            turn_q       <= (FIRST_X != 0);
            resp_valid_q <= 1'b0;
            resp_code_q  <= RESP_OK;
        end else begin
            board_q      <= board_d;
            resp_valid_q <= mv.move_valid;
            resp_code_q  <= resp_code_d;
            if (accept) turn_q <= !turn_q;
        end
    end

    piece_queue #(.DEPTH(QD), .PW(PW)) u_xq (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (accept && turn_q),
        .pop   (evict && turn_q),
        .din   (mv.move_pos),
        .head  (xq_head),
        .count (xq_cnt)
    );

    piece_queue #(.DEPTH(QD), .PW(PW)) u_oq (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (accept && !turn_q),
        .pop   (evict && !turn_q),
        .din   (mv.move_pos),
        .head  (oq_head),
        .count (oq_cnt)
    );

    assign board         = board_q;
    assign turn_x        = turn_q;
    assign x_count       = CW'(xq_cnt);
    assign o_count       = CW'(oq_cnt);
    assign fade_valid    = (FADE_EN != 0) && (mover_cnt == QCW'(DEPTH));
    assign fade_pos      = fade_valid ? mover_head : '0;
    assign mv.resp_valid = resp_valid_q;
    assign mv.resp_code  = resp_code_q;
endmodule

// File: tb/tb_fading_move_board.sv
// Directed bench for fading_move_board: fading instance driven from a vector table, classic instance by hand.
module tb_fading_move_board;
    logic clk = 1'b0;
    logic rst;
    logic clr_a, frz_a, clr_b, frz_b;
    logic [17:0] brd_a, brd_b;
    logic tx_a, tx_b, fv_a, fv_b;
    logic [3:0] xc_a, oc_a, xc_b, oc_b, fp_a, fp_b;
    int total = 0;
    int bad   = 0;

    fading_move_board_if #(.PW(4)) ifa ();
    fading_move_board_if #(.PW(4)) ifb ();

    fading_move_board #(.CELLS(9), .DEPTH(3), .FADE_EN(1), .FIRST_X(1)) dut_a (
        .clk(clk), .rst(rst), .clear(clr_a), .freeze(frz_a), .mv(ifa),
        .board(brd_a), .turn_x(tx_a), .x_count(xc_a), .o_count(oc_a),
        .fade_valid(fv_a), .fade_pos(fp_a)
    );

    fading_move_board #(.CELLS(9), .DEPTH(3), .FADE_EN(0), .FIRST_X(1)) dut_b (
        .clk(clk), .rst(rst), .clear(clr_b), .freeze(frz_b), .mv(ifb),
        .board(brd_b), .turn_x(tx_b), .x_count(xc_b), .o_count(oc_b),
        .fade_valid(fv_b), .fade_pos(fp_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        clr, frz, mv, mx;
        logic [3:0]  pos;
        logic        rv;
        logic [1:0]  rc;
        logic [17:0] brd;
        logic        tx;
        logic [3:0]  xc, oc;
        logic        fv;
        logic [3:0]  fp;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // clr frz mv mx pos | rv rc board tx xc oc fv fp
        vt[0]  = '{0,0,1,1,4, 1,2'd0,18'h00200,0,1,0,0,0};
        vt[1]  = '{0,0,1,1,0, 1,2'd1,18'h00200,0,1,0,0,0};
        vt[2]  = '{0,0,1,0,4, 1,2'd2,18'h00200,0,1,0,0,0};
        vt[3]  = '{0,0,1,0,3, 1,2'd0,18'h00240,1,1,1,0,0};
        vt[4]  = '{0,1,1,1,0, 1,2'd3,18'h00240,1,1,1,0,0};
        vt[5]  = '{0,0,1,1,9, 1,2'd3,18'h00240,1,1,1,0,0};
        vt[6]  = '{1,0,1,1,0, 0,2'd0,18'h00000,1,0,0,0,0};
        vt[7]  = '{0,0,1,1,0, 1,2'd0,18'h00002,0,1,0,0,0};
        vt[8]  = '{0,0,1,0,3, 1,2'd0,18'h00042,1,1,1,0,0};
        vt[9]  = '{0,0,1,1,1, 1,2'd0,18'h0004A,0,2,1,0,0};
        vt[10] = '{0,0,1,0,4, 1,2'd0,18'h0014A,1,2,2,0,0};
        vt[11] = '{0,0,1,1,2, 1,2'd0,18'h0016A,0,3,2,0,0};
        vt[12] = '{0,0,1,0,8, 1,2'd0,18'h1016A,1,3,3,1,0};
        vt[13] = '{0,0,1,1,0, 1,2'd2,18'h1016A,1,3,3,1,0};
        vt[14] = '{0,0,1,1,6, 1,2'd0,18'h12168,0,3,3,1,3};
        vt[15] = '{0,0,1,0,5, 1,2'd0,18'h12528,1,3,3,1,1};
        vt[16] = '{0,0,1,0,7, 1,2'd1,18'h12528,1,3,3,1,1};
        vt[17] = '{0,0,0,1,0, 0,2'd1,18'h12528,1,3,3,1,1};
        vt[18] = '{0,0,1,1,7, 1,2'd0,18'h1A520,0,3,3,1,4};

        rst = 1'b1; clr_a = 0; frz_a = 0; clr_b = 0; frz_b = 0;
        ifa.move_valid = 0; ifa.move_x = 0; ifa.move_pos = '0;
        ifb.move_valid = 0; ifb.move_x = 0; ifb.move_pos = '0;
        step(); step();
        rst = 1'b0;
        step();

        check("reset board",  32'(brd_a), 32'h0);
        check("reset turn",   32'(tx_a), 32'h1);
        check("reset xcount", 32'(xc_a), 32'h0);
        check("reset ocount", 32'(oc_a), 32'h0);
        check("reset rvalid", 32'(ifa.resp_valid), 32'h0);
        check("reset rcode",  32'(ifa.resp_code), 32'h0);
        check("reset fade",   32'({fv_a, fp_a}), 32'h0);

        for (int i = 0; i < 19; i++) begin
            clr_a = vt[i].clr; frz_a = vt[i].frz;
            ifa.move_valid = vt[i].mv; ifa.move_x = vt[i].mx; ifa.move_pos = vt[i].pos;
            step();
            check($sformatf("v%0d rvalid", i), 32'(ifa.resp_valid), 32'(vt[i].rv));
            check($sformatf("v%0d rcode", i),  32'(ifa.resp_code),  32'(vt[i].rc));
            check($sformatf("v%0d board", i),  32'(brd_a), 32'(vt[i].brd));
            check($sformatf("v%0d turn", i),   32'(tx_a),  32'(vt[i].tx));
            check($sformatf("v%0d xcount", i), 32'(xc_a),  32'(vt[i].xc));
            check($sformatf("v%0d ocount", i), 32'(oc_a),  32'(vt[i].oc));
            check($sformatf("v%0d fvalid", i), 32'(fv_a),  32'(vt[i].fv));
            check($sformatf("v%0d fpos", i),   32'(fp_a),  32'(vt[i].fp));
        end
        clr_a = 0; frz_a = 0; ifa.move_valid = 0;

        // Reset mid-game with a move pending: the move must be discarded.
        rst = 1'b1; ifa.move_valid = 1; ifa.move_x = 0; ifa.move_pos = 4'd0;
        step();
        rst = 1'b0; ifa.move_valid = 0;
        check("midrst board",  32'(brd_a), 32'h0);
        check("midrst turn",   32'(tx_a), 32'h1);
        check("midrst counts", 32'({xc_a, oc_a}), 32'h0);
        check("midrst rvalid", 32'(ifa.resp_valid), 32'h0);
        check("midrst fade",   32'(fv_a), 32'h0);

        // Classic board: fill all nine cells alternately, nothing may be evicted.
        for (int i = 0; i < 9; i++) begin
            ifb.move_valid = 1; ifb.move_x = (i % 2 == 0); ifb.move_pos = 4'(i);
            step();
            check($sformatf("classic m%0d rvalid", i), 32'(ifb.resp_valid), 32'h1);
            check($sformatf("classic m%0d rcode", i),  32'(ifb.resp_code), 32'h0);
            check($sformatf("classic m%0d fvalid", i), 32'(fv_b), 32'h0);
        end
        check("classic board",  32'(brd_b), 32'h26666);
        check("classic xcount", 32'(xc_b), 32'd5);
        check("classic ocount", 32'(oc_b), 32'd4);
        check("classic turn",   32'(tx_b), 32'h0);

        ifb.move_x = 0; ifb.move_pos = 4'd0;
        step();
        ifb.move_valid = 0;
        check("classic full rcode", 32'(ifb.resp_code), 32'h2);
        check("classic full board", 32'(brd_b), 32'h26666);

        // Clear on the classic instance without a move.
        clr_b = 1;
        step();
        clr_b = 0;
        check("classic clear board", 32'(brd_b), 32'h0);
        check("classic clear turn",  32'(tx_b), 32'h1);
        check("classic clear counts", 32'({xc_b, oc_b}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
